uart_rx_buffer_ctrl: RTL and testbench

- Controller between the UART receiver core and the CPU peripheral bus.
- Drains each received byte from the receiver with a one-cycle read acknowledge and stores it in a small FIFO.
- Exposes the FIFO to the CPU, with level, interrupt and sticky overrun status.
- Drives the combined active-high (busy) RTS line, asserted early as the FIFO nears full, so the far end pauses before bytes are dropped.

---
 rtl/uart_rx_buffer_ctrl_if.sv | 32 +++
 rtl/uart_rx_buffer_ctrl.sv | 107 ++++++++++
 tb/tb_uart_rx_buffer_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_buffer_ctrl_if.sv
// rtl/uart_rx_buffer_ctrl_if.sv - receiver handshake and CPU-side bus of the UART RX buffer controller
interface uart_rx_buffer_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_busy_rts;
  logic          rx_read;
  logic          uart_rts;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          data_avail;
  logic [LW-1:0] level;
  logic          irq;
  logic          overrun;
  logic          clr_overrun;
  logic          flush;

  // Receiver core plus CPU side
  modport master (
    output rx_valid, rx_data, rx_busy_rts, rd_en, clr_overrun, flush,
    input  rx_read, uart_rts, rd_data, data_avail, level, irq, overrun
  );

  // Buffer controller
  modport slave (
    input  rx_valid, rx_data, rx_busy_rts, rd_en, clr_overrun, flush,
    output rx_read, uart_rts, rd_data, data_avail, level, irq, overrun
  );
endinterface

// File: rtl/uart_rx_buffer_ctrl.sv
// rtl/uart_rx_buffer_ctrl.sv - drains the UART receiver into a small FIFO with level, irq, overrun and RTS
module uart_rx_buffer_ctrl #(
  parameter int DEPTH     = 4,
  parameter int RTS_FREE  = 1,
  parameter int IRQ_LEVEL = 1
) (
  input logic                  clk,
  input logic                  resetn,
  uart_rx_buffer_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          overrun_q;
  logic          uart_rts_q;
  logic          rx_read_o;
  logic          capture;
  logic          full;
  logic          push;
  logic          drop;
  logic          pop;

  // Capture FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Capture FSM next state: one ACK cycle per received byte
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.rx_valid) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture FSM outputs: sample the byte in IDLE, acknowledge in ACK (rx_valid still high there)
  always_comb begin
    rx_read_o = 1'b0;
    capture   = 1'b0;
    case (state_q)
      S_IDLE:  capture   = bus.rx_valid;
      S_ACK:   rx_read_o = 1'b1;
      default: ;
    endcase
  end

  // Fullness is judged before any same-cycle pop; flush swallows both push and pop
  assign full = (level_q == LW'(DEPTH));
  assign push = capture && !full && !bus.flush;
  assign drop = capture &&  full && !bus.flush;
  assign pop  = bus.rd_en && (level_q != '0) && !bus.flush;

  // Level after this edge; also feeds the registered RTS so both change together
  always_comb begin
    level_d = level_q;
    if (bus.flush) level_d = '0;
    else           level_d = level_q + LW'(push) - LW'(pop);
  end

  // Pointers, level, sticky overrun and RTS
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      uart_rts_q <= 1'b1;
    end else begin
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      if (drop)                 overrun_q <= 1'b1;
      else if (bus.clr_overrun) overrun_q <= 1'b0;
      uart_rts_q <= bus.rx_busy_rts || ((LW'(DEPTH) - level_d) <= LW'(RTS_FREE));
    end
  end

  // FIFO storage; contents are don't-care while level says empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rx_read    = rx_read_o;
  assign bus.uart_rts   = uart_rts_q;
  assign bus.rd_data    = (level_q != '0) ? mem[rd_ptr_q] : 8'h00;
  assign bus.data_avail = (level_q != '0);
  assign bus.level      = level_q;
  assign bus.irq        = (level_q >= LW'(IRQ_LEVEL));
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx_buffer_ctrl.sv
// tb/tb_uart_rx_buffer_ctrl.sv - scoreboard bench for uart_rx_buffer_ctrl
module tb_uart_rx_buffer_ctrl;
  localparam int DEPTH     = 4;
  localparam int RTS_FREE  = 1;
  localparam int IRQ_LEVEL = 1;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  uart_rx_buffer_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_buffer_ctrl #(
    .DEPTH    (DEPTH),
    .RTS_FREE (RTS_FREE),
    .IRQ_LEVEL(IRQ_LEVEL)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO contents as a queue, plus the flags visible next cycle
  logic [7:0] mq [$];
  logic [7:0] exp_q [$];
  bit         m_over = 1'b0;
  bit         m_rts  = 1'b1;
  bit         m_ack  = 1'b0;

  // Model state visible in the current cycle
  int         cur_level = 0;
  bit         cur_over  = 1'b0;
  bit         cur_rts   = 1'b1;
  bit         cur_ack   = 1'b0;
  bit         mon_en    = 1'b0;

  int         rx_phase  = 0;
  int         n_checks  = 0;
  int         n_fail    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model is advanced by the same rules in the same call
  task automatic step(input bit nb, input logic [7:0] d, input bit rd, input bit clr,
                      input bit fl, input bit busy, input bit rst);
    bit cap;
    bit full;
    bit can_pop;
    @(posedge clk);
    #1;
    cur_level = mq.size();
    cur_over  = m_over;
    cur_rts   = m_rts;
    cur_ack   = m_ack;
    m_ack     = 1'b0;
    cap       = 1'b0;
    resetn    = !rst;
    if (rx_phase == 1) begin
      bus.rx_valid = 1'b1;
      rx_phase     = 0;
    end else if (nb && !rst) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = d;
      rx_phase     = 1;
      cap          = 1'b1;
    end else begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
    if (rst) rx_phase = 0;
    bus.rd_en       = rd;
    bus.clr_overrun = clr;
    bus.flush       = fl;
    bus.rx_busy_rts = busy;
    if (rst) begin
      mq.delete();
      m_over = 1'b0;
      m_rts  = 1'b1;
      m_ack  = 1'b0;
    end else begin
      full    = (mq.size() == DEPTH);
      can_pop = rd && (mq.size() != 0);
      if (fl) mq.delete();
      else begin
        if (can_pop) exp_q.push_back(mq.pop_front());
        if (cap && !full) mq.push_back(d);
      end
      if (cap) m_ack = 1'b1;
      if (cap && full && !fl) m_over = 1'b1;
      else if (clr)           m_over = 1'b0;
      m_rts = busy || ((DEPTH - mq.size()) <= RTS_FREE);
    end
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each CPU read
  always @(negedge clk) begin
    if (mon_en) begin
      chk("level", 32'(bus.level), 32'(cur_level));
      chk("data_avail", 32'(bus.data_avail), 32'(cur_level != 0));
      chk("irq", 32'(bus.irq), 32'(cur_level >= IRQ_LEVEL));
      chk("overrun", 32'(bus.overrun), 32'(cur_over));
      chk("uart_rts", 32'(bus.uart_rts), 32'(cur_rts));
      chk("rx_read", 32'(bus.rx_read), 32'(cur_ack));
      if (cur_level == 0) chk("rd_data_empty", 32'(bus.rd_data), 32'h0);
      if (resetn && bus.rd_en && bus.data_avail && !bus.flush) begin
        if (exp_q.size() == 0) chk("pop_without_expected", 32'(exp_q.size()), 32'd1);
        else                   chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    bus.rx_valid    = 1'b0;
    bus.rx_data     = 8'h00;
    bus.rx_busy_rts = 1'b0;
    bus.rd_en       = 1'b0;
    bus.clr_overrun = 1'b0;
    bus.flush       = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;

    // Single byte, then pop
    send(8'hA5);
    idle();
    pop1();
    idle();

    // Wrap ordering
    for (int i = 1; i <= 4; i++) send(8'(i));
    pop1(); pop1();
    send(8'h05); send(8'h06);
    for (int i = 0; i < 4; i++) pop1();
    idle();

    // RTS threshold: fill to 3, pop one, then fill to 4
    send(8'h11); send(8'h12); send(8'h13);
    pop1();
    send(8'h14); send(8'h15);
    idle();

    // Overrun at full, clear racing a drop, then clear alone, then head check
    send(8'h77);
    step(1'b1, 8'h78, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    pop1();

    // Simultaneous push and pop at level 2, at full, and rd_en while empty
    pop1();
    step(1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    send(8'h22); send(8'h23);
    step(1'b1, 8'h24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) pop1();
    pop1();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Flush with a same-cycle push at level 3, then reset during ACK
    send(8'h31); send(8'h32); send(8'h33);
    step(1'b1, 8'h34, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    send(8'h41);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    idle();

    // Randomized traffic with alternating drain pressure
    for (int i = 0; i < 3000; i++) begin
      int rd_pct;
      rd_pct = ((i / 300) % 2 == 0) ? 15 : 65;
      step(1'($urandom_range(0, 1)), 8'($urandom),
           ($urandom_range(0, 99) < rd_pct),
           ($urandom_range(0, 99) < 8),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 999) < 5));
    end

    for (int i = 0; i < 8; i++) pop1();
    idle();
    idle();
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
